// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer behind the radix-2^2 SDF FFT: takes bit-reversed frames
// from the last stage and replays them in natural order over valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | output register not being refilled; waiting for a full bank
// S_STREAM| reading bank r_rd_bank in natural order, one load per slot
module fft_reorder #(
    parameter int data_width  = 13,
    parameter int log2_points = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic [data_width-1:0] in_r,
    input  logic [data_width-1:0] in_i,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [data_width-1:0] out_r,
    output logic [data_width-1:0] out_i,
    output logic                  out_last,
    input  logic                  overflow_clr,
    output logic                  overflow
);

    localparam int N = 2 ** log2_points;

    typedef logic [log2_points-1:0] addr_t;
    localparam addr_t LAST_IDX = addr_t'(N - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } rd_state_t;

    function automatic addr_t bitrev(input addr_t a);
        addr_t b;
        for (int k = 0; k < log2_points; k++) begin
            b[k] = a[log2_points-1-k];
        end
        return b;
    endfunction

    // Bank select is the address MSB; each entry packs {real, imag}.
    logic [2*data_width-1:0] r_mem [0:2*N-1];

    addr_t     r_wr_cnt;
    logic      r_wr_bank;
    logic      r_drop;
    logic [1:0] r_full;
    logic      r_overflow;

    addr_t     r_rd_cnt;
    logic      r_rd_bank;
    rd_state_t r_state;
    rd_state_t w_state_nxt;

    logic                  r_out_valid;
    logic                  r_out_last;
    logic [data_width-1:0] r_out_r;
    logic [data_width-1:0] r_out_i;

    addr_t        w_idx;
    logic         w_frame_start;
    logic         w_frame_end;
    logic         w_start_blocked;
    logic         w_drop_eff;
    logic         w_wr_en;
    logic [log2_points:0] w_wr_addr;
    logic         w_commit;

    logic         w_out_free;
    logic         w_load;
    logic         w_load_last;
    addr_t        w_load_addr;
    logic [2*data_width-1:0] w_rd_data;
    logic [1:0]   w_full_set;
    logic [1:0]   w_full_clr;

    // ---------------- write side ----------------
    always_comb begin
        w_idx           = in_first ? '0 : r_wr_cnt;
        w_frame_start   = in_valid && (w_idx == '0);
        w_frame_end     = in_valid && (w_idx == LAST_IDX);
        w_start_blocked = r_full[r_wr_bank];
        // A frame start decides its own fate from the full flag; later samples follow r_drop.
        w_drop_eff      = (w_idx == '0) ? w_start_blocked : r_drop;
        w_wr_en         = in_valid && !w_drop_eff;
        w_wr_addr       = {r_wr_bank, bitrev(w_idx)};
        w_commit        = w_frame_end && !w_drop_eff;
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= {in_r, in_i};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
            r_drop    <= 1'b0;
        end else if (in_valid) begin
            r_wr_cnt <= w_idx + 1'b1;
            if (w_frame_start) begin
                r_drop <= w_start_blocked;
            end else if (w_frame_end && r_drop) begin
                r_drop <= 1'b0;
            end
            if (w_commit) begin
                r_wr_bank <= !r_wr_bank;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_frame_start && w_start_blocked) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // ---------------- read side ----------------
    always_comb begin
        w_out_free  = !r_out_valid || out_ready;
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_last = 1'b0;
        w_load_addr = r_rd_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_bank] && w_out_free) begin
                    w_load      = 1'b1;
                    w_load_addr = '0;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_out_free) begin
                    w_load = 1'b1;
                    if (r_rd_cnt == LAST_IDX) begin
                        w_load_last = 1'b1;
                        w_state_nxt = r_full[!r_rd_bank] ? S_STREAM : S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_rd_data = r_mem[{r_rd_bank, w_load_addr}];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rd_cnt  <= '0;
            r_rd_bank <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                if (w_load_last) begin
                    r_rd_cnt  <= '0;
                    r_rd_bank <= !r_rd_bank;
                end else begin
                    r_rd_cnt <= w_load_addr + 1'b1;
                end
            end
        end
    end

    // Set and clear only ever target different banks, so one merged update suffices.
    always_comb begin
        w_full_set = 2'b00;
        w_full_clr = 2'b00;
        w_full_set[r_wr_bank] = w_commit;
        w_full_clr[r_rd_bank] = w_load_last;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full & ~w_full_clr) | w_full_set;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_r     <= '0;
            r_out_i     <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_load_last;
            r_out_r     <= w_rd_data[2*data_width-1:data_width];
            r_out_i     <= w_rd_data[data_width-1:0];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_r     = r_out_r;
    assign out_i     = r_out_i;
    assign out_last  = r_out_last;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_fft_reorder.sv
// Scoreboard bench for fft_reorder at N=8: expected natural-order samples are queued
// as frames are driven and popped when the DUT hands a sample over.
module tb_fft_reorder;

    localparam int DW = 13;
    localparam int LP = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid, in_first, out_ready, overflow_clr;
    logic [DW-1:0] in_r, in_i;
    logic          out_valid, out_last, overflow;
    logic [DW-1:0] out_r, out_i;

    typedef struct packed {
        logic [DW-1:0] r;
        logic [DW-1:0] i;
        logic          last;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   order_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_accept = 0;
    int   n_last = 0;
    bit   rnd_done;

    fft_reorder #(.data_width(DW), .log2_points(LP)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_first     (in_first),
        .in_r         (in_r),
        .in_i         (in_i),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_r        (out_r),
        .out_i        (out_i),
        .out_last     (out_last),
        .overflow_clr (overflow_clr),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_accept++;
            if (out_last === 1'b1) n_last++;
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_unexpected: got r=%0d i=%0d last=%0b, required no output",
                         out_r, out_i, out_last);
            end else begin
                m_e = q.pop_front();
                if ({out_r, out_i, out_last} !== m_e) begin
                    n_fail++;
                    $display("FAIL scoreboard_data: got r=%0d i=%0d last=%0b, required r=%0d i=%0d last=%0b",
                             out_r, out_i, out_last, m_e.r, m_e.i, m_e.last);
                end
            end
        end
    end

    task automatic send_frame(input int base, input int nsamp, input bit push);
        exp_t e;
        if (push) begin
            for (int n = 0; n < 8; n++) begin
                e.r    = DW'(base + order_tab[n]);
                e.i    = DW'(100 + base + order_tab[n]);
                e.last = (n == 7);
                q.push_back(e);
            end
        end
        for (int k = 0; k < nsamp; k++) begin
            @(posedge clock); #1;
            in_valid = 1'b1;
            in_first = (k == 0);
            in_r     = DW'(base + k);
            in_i     = DW'(100 + base + k);
        end
    endtask

    task automatic idle_in();
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(posedge clock); #1;
            if (q.size() == 0 && out_valid === 1'b0) done = 1'b1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d samples outstanding, required 0", name, q.size());
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_tests++;
        if ({out_valid, out_r, out_i, out_last, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b r=%0d i=%0d last=%0b ovf=%0b, required all 0",
                     out_valid, out_r, out_i, out_last, overflow);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_frame();
        out_ready = 1'b1;
        send_frame(0, 8, 1'b1);
        idle_in();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency_early: got valid=%0b, required 0", out_valid);
        end
        @(posedge clock); #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_r !== DW'(0) || out_i !== DW'(100)) begin
            n_fail++;
            $display("FAIL single_latency_first: got valid=%0b r=%0d i=%0d, required valid=1 r=0 i=100",
                     out_valid, out_r, out_i);
        end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_last !== (k == 7)) begin
                n_fail++;
                $display("FAIL single_stream_%0d: got valid=%0b last=%0b, required valid=1 last=%0b",
                         k, out_valid, out_last, (k == 7));
            end
            @(posedge clock); #1;
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: got valid=%0b, required 0", out_valid);
        end
        wait_drain("single");
    endtask

    task automatic test_back_to_back();
        int gaps;
        bit seen;
        out_ready = 1'b1;
        gaps = 0;
        seen = 1'b0;
        fork
            begin
                send_frame(200, 8, 1'b1);
                send_frame(300, 8, 1'b1);
                send_frame(400, 8, 1'b1);
                idle_in();
            end
            begin
                for (int c = 0; c < 60 && !seen; c++) begin
                    @(posedge clock); #1;
                    if (out_valid === 1'b1) seen = 1'b1;
                end
                for (int k = 1; k < 24; k++) begin
                    @(posedge clock); #1;
                    if (out_valid !== 1'b1) gaps++;
                end
                @(posedge clock); #1;
            end
        join
        n_tests++;
        if (!seen || gaps != 0) begin
            n_fail++;
            $display("FAIL b2b_gapless: got seen=%0b gaps=%0d, required seen=1 gaps=0", seen, gaps);
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got valid=%0b, required 0", out_valid);
        end
        wait_drain("b2b");
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_overflow: got %0b, required 0", overflow);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] hr, hi;
        logic          hl;
        int            unstable;
        out_ready = 1'b0;
        send_frame(0, 8, 1'b1);
        send_frame(20, 8, 1'b1);
        send_frame(40, 8, 1'b0);
        idle_in();
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_overflow_set: got %0b, required 1", overflow);
        end
        n_tests++;
        if (out_valid !== 1'b1 || out_r !== DW'(0) || out_i !== DW'(100)) begin
            n_fail++;
            $display("FAIL bp_head: got valid=%0b r=%0d i=%0d, required valid=1 r=0 i=100",
                     out_valid, out_r, out_i);
        end
        hr = out_r; hi = out_i; hl = out_last;
        unstable = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            if (out_valid !== 1'b1 || out_r !== hr || out_i !== hi || out_last !== hl) unstable++;
        end
        n_tests++;
        if (unstable != 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d changed cycles, required 0", unstable);
        end
        out_ready = 1'b1;
        wait_drain("bp");
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_overflow_sticky: got %0b, required 1", overflow);
        end
        overflow_clr = 1'b1;
        @(posedge clock); #1;
        overflow_clr = 1'b0;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_overflow_clr: got %0b, required 0", overflow);
        end
    endtask

    task automatic test_resync();
        out_ready = 1'b1;
        send_frame(50, 5, 1'b0);
        send_frame(10, 8, 1'b1);
        idle_in();
        wait_drain("resync");
        repeat (10) @(posedge clock);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            n_fail++;
            $display("FAIL resync_no_partial: got valid=%0b pending=%0d, required valid=0 pending=0",
                     out_valid, q.size());
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        send_frame(30, 8, 1'b1);
        idle_in();
        repeat (4) @(posedge clock);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_r !== DW'(36)) begin
            n_fail++;
            $display("FAIL rst_mid_4th: got valid=%0b r=%0d, required valid=1 r=36", out_valid, out_r);
        end
        reset = 1'b1;
        #1;
        q.delete();
        n_tests++;
        if ({out_valid, out_r, out_i, out_last} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got valid=%0b r=%0d i=%0d last=%0b, required all 0",
                     out_valid, out_r, out_i, out_last);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        send_frame(60, 8, 1'b1);
        idle_in();
        @(posedge clock); #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_r !== DW'(60) || out_i !== DW'(160)) begin
            n_fail++;
            $display("FAIL rst_mid_fresh: got valid=%0b r=%0d i=%0d, required valid=1 r=60 i=160",
                     out_valid, out_r, out_i);
        end
        wait_drain("rst_mid");
    endtask

    task automatic test_random_ready();
        int a0, l0;
        bit ok;
        a0 = n_accept;
        l0 = n_last;
        rnd_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 10; f++) begin
                    ok = 1'b0;
                    for (int c = 0; c < 2000 && !ok; c++) begin
                        if (q.size() <= 8) ok = 1'b1;
                        else begin @(posedge clock); #1; end
                    end
                    send_frame(f * 37 % 300, 8, 1'b1);
                    idle_in();
                end
                wait_drain("rand");
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clock); #1;
                    out_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        out_ready = 1'b1;
        n_tests++;
        if (n_accept - a0 != 80 || n_last - l0 != 10) begin
            n_fail++;
            $display("FAIL rand_counts: got accepted=%0d lasts=%0d, required accepted=80 lasts=10",
                     n_accept - a0, n_last - l0);
        end
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_overflow: got %0b, required 0", overflow);
        end
    endtask

    initial begin
        in_valid     = 1'b0;
        in_first     = 1'b0;
        in_r         = '0;
        in_i         = '0;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_resync();
        test_reset_midstream();
        test_random_ready();
        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fft_reorder.md
Name: fft_reorder

Overview:
- Output-side reader for the radix-2^2 SDF FFT pipeline.
- Accepts the last stage's bit-reversed-order sample stream (real/imag, one sample per enabled cycle, no backpressure possible) and re-emits each frame in natural order over a valid/ready interface.
- Uses a two-bank ping-pong buffer: the pipeline writes one bank while the downstream reads the other.

Parameters:
- data_width, 13, width of each real/imag sample.
- log2_points, 6, log2 of FFT size N (N = 2^log2_points points per frame, per bank).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present on in_r/in_i this cycle (pipeline enable).
- in_first  in  1  qualified by in_valid; marks bit-reversed index 0 of a frame.
- in_r  in  data_width  real part from final stage.
- in_i  in  data_width  imaginary part from final stage.
- out_ready  in  1  downstream accepts output this cycle.
- out_valid  out  1  out_r/out_i/out_last hold a valid sample.
- out_r  out  data_width  real part, natural order.
- out_i  out  data_width  imaginary part, natural order.
- out_last  out  1  marks natural index N-1.
- overflow_clr  in  1  synchronous clear of overflow.
- overflow  out  1  sticky: a frame was dropped because both banks were occupied.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_r=0, out_i=0, out_last=0, overflow=0.
  - wr_cnt=0, wr_bank=0, rd_cnt=0, rd_bank=0, full[1:0]=0, drop=0, read FSM=IDLE.
  - RAM contents are not reset.
- Write side, on each in_valid cycle:
  - Effective index idx = 0 if in_first, else wr_cnt.
  - The sample is written to bank wr_bank at address bitrev(idx) over log2_points bits, unless drop=1.
  - wr_cnt is then set to idx+1, modulo N.
- Frame start (idx==0):
  - If full[wr_bank]=1, set drop=1 and overflow=1; the whole frame is discarded but counted.
  - Otherwise set drop=0.
- Frame end (idx==N-1):
  - If drop=0, set full[wr_bank]=1 and toggle wr_bank.
  - If drop=1, clear drop; wr_bank is unchanged.
- in_first mid-frame: the partial frame is abandoned. The counter restarts at 0 in the same bank; that bank's full flag is not set.
- Read FSM has two states:
  - IDLE → STREAM when full[rd_bank]=1 and the output register is empty or being accepted. Entering STREAM loads address rd_cnt=0.
  - STREAM: the output register loads RAM[rd_bank][rd_cnt] when (!out_valid || out_ready). rd_cnt increments per load.
  - The load with rd_cnt==N-1 sets out_last=1 and clears full[rd_bank] on the same edge. rd_bank toggles and rd_cnt returns to 0.
  - The FSM stays in STREAM if the other bank is already full (back-to-back frames, no bubble); otherwise it returns to IDLE.
- Output handshake:
  - out_valid/out_r/out_i/out_last are registered.
  - They are held stable while out_valid=1 and out_ready=0.
  - out_valid drops after acceptance when no further load occurs.
- Latency: the final write of a frame at edge T gives out_valid=1 with natural index 0 at edge T+1. With out_ready held high, N consecutive valid cycles follow.
- Simultaneous events:
  - A writer frame start on a bank whose full flag is cleared on the same edge by the reader sees the flag still set, so the frame is dropped. The read of a released bank completes before a write into it.
  - Writer set and reader clear on different banks in the same edge are independent.
  - overflow_clr and a new overflow in the same cycle leave overflow=1.
- Throughput: sustains 1 sample/cycle in and out continuously.

Test Plan (log2_points=3, N=8, data_width=13):
- Single frame: in_first on the first sample, in_r = 0,1,...,7 over 8 consecutive cycles, in_i = 100+in_r, out_ready=1.
  - Required: out_valid rises the cycle after the 8th write.
  - out_r = 0,4,2,6,1,5,3,7 and out_i = 100+out_r.
  - out_last only on the 8th output.
- Continuous 3 frames, out_ready=1: 24 outputs on consecutive cycles with no gap between frames; overflow stays 0.
- Backpressure: out_ready held 0 for 20 cycles while 3 frames arrive.
  - Required: the third frame is dropped and overflow=1.
  - After out_ready=1, frames 1 and 2 emerge intact with outputs stable while stalled.
  - overflow_clr pulse gives overflow=0.
- Mid-frame resync: 5 samples, then in_first with values 10..17.
  - Required: output is only the reordered 10..17 frame (10,14,12,16,11,15,13,17); no partial frame emitted.
- Reset mid-stream: assert reset during the 4th output.
  - Required: outputs immediately 0, out_valid=0.
  - After release, a fresh frame reorders correctly starting in bank 0.
- Random out_ready toggling (50%) over 10 frames: every accepted sample matches the bitrev model, and out_last appears exactly every 8 accepted samples.
